mem_arbiter: RTL and testbench

Arbitrates a single-port synchronous 2048x32 SRAM macro between the instruction-fetch port (IF) and the data-memory port (DM) of the 5-stage pipeline. This lets one macro replace the separate instruction and data instances. DM has priority by default. A starvation counter guarantees fetch forward progress. A denied grant acts as a stall request, which the hazard unit ORs into PC write and IF/ID stall.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one 2048x32 single-port SRAM between instruction fetch and data memory.
// Data side wins by default; a run counter forces fetch through after MAX_DM_RUN losses.
module mem_arbiter #(
   parameter int WIDTH      = 32,
   parameter int ADDR_W     = 11,
   parameter int MAX_DM_RUN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IF_REQ,
   input  logic [WIDTH-1:0]  IF_ADDR,
   output logic              IF_GNT,
   output logic              IF_VALID,
   output logic [WIDTH-1:0]  IF_RDATA,
   input  logic              DM_REQ,
   input  logic              DM_WE,
   input  logic [WIDTH-1:0]  DM_ADDR,
   input  logic [WIDTH-1:0]  DM_WDATA,
   output logic              DM_GNT,
   output logic              DM_VALID,
   output logic [WIDTH-1:0]  DM_RDATA,
   output logic              SRAM_CEN,
   output logic              SRAM_WEN,
   output logic [ADDR_W-1:0] SRAM_A,
   output logic [WIDTH-1:0]  SRAM_D,
   input  logic [WIDTH-1:0]  SRAM_Q
);

   localparam logic [0:0] PRIO_DM = 1'b0;
   localparam logic [0:0] PRIO_IF = 1'b1;

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_IF    = 2'd1;
   localparam logic [1:0] OWN_DM_RD = 2'd2;
   localparam logic [1:0] OWN_DM_WR = 2'd3;

   localparam logic [3:0] RUN_MAX = 4'(MAX_DM_RUN);

   logic [0:0]        prio_q, prio_d;
   logic [3:0]        run_q, run_d;
   logic [1:0]        own_q, own_d;
   logic [ADDR_W-1:0] a_q;
   logic [WIDTH-1:0]  d_q;
   logic              if_gnt, dm_gnt, any_gnt;
   logic              unused_addr_bits;

   // Grants are masked while reset is held so the macro stays idle
   always_comb begin
      if_gnt  = rst & IF_REQ & (~DM_REQ | (prio_q == PRIO_IF));
      dm_gnt  = rst & DM_REQ & ~if_gnt;
      any_gnt = if_gnt | dm_gnt;
   end

   always_comb begin
      run_d = run_q;
      if (!IF_REQ || if_gnt)
         run_d = '0;
      else if (dm_gnt && run_q != RUN_MAX)
         run_d = run_q + 4'd1;
   end

   always_comb begin
      prio_d = prio_q;
      unique case (prio_q)
         PRIO_DM: if (run_d == RUN_MAX) prio_d = PRIO_IF;
         PRIO_IF: if (if_gnt)           prio_d = PRIO_DM;
         default: prio_d = PRIO_DM;
      endcase
   end

   always_comb begin
      own_d = OWN_NONE;
      if (if_gnt)
         own_d = OWN_IF;
      else if (dm_gnt)
         own_d = DM_WE ? OWN_DM_WR : OWN_DM_RD;
   end

   // Address and data hold their last value on idle cycles
   always_comb begin
      SRAM_A = a_q;
      if (if_gnt)
         SRAM_A = IF_ADDR[ADDR_W+1:2];
      else if (dm_gnt)
         SRAM_A = DM_ADDR[ADDR_W+1:2];
      SRAM_D   = any_gnt ? DM_WDATA : d_q;
      SRAM_CEN = ~any_gnt;
      SRAM_WEN = ~(dm_gnt & DM_WE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_q <= PRIO_DM;
         run_q  <= '0;
         own_q  <= OWN_NONE;
         a_q    <= '0;
         d_q    <= '0;
      end else begin
         prio_q <= prio_d;
         run_q  <= run_d;
         own_q  <= own_d;
         a_q    <= SRAM_A;
         d_q    <= SRAM_D;
      end
   end

   always_comb begin
      IF_GNT   = if_gnt;
      DM_GNT   = dm_gnt;
      IF_VALID = (own_q == OWN_IF);
      DM_VALID = (own_q == OWN_DM_RD) | (own_q == OWN_DM_WR);
      IF_RDATA = IF_VALID ? SRAM_Q : '0;
      DM_RDATA = (own_q == OWN_DM_RD) ? SRAM_Q : '0;
   end

   assign unused_addr_bits = ^{IF_ADDR[1:0], IF_ADDR[WIDTH-1:ADDR_W+2],
                               DM_ADDR[1:0], DM_ADDR[WIDTH-1:ADDR_W+2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized traffic,
// checked against a word-array memory model and a starvation-rule grant model.
module tb_mem_arbiter;

   localparam int WIDTH  = 32;
   localparam int ADDR_W = 11;
   localparam int MAXR   = 4;
   localparam int WORDS  = 2048;

   logic              clk = 1'b0;
   logic              rst;
   logic              IF_REQ, IF_GNT, IF_VALID;
   logic [WIDTH-1:0]  IF_ADDR, IF_RDATA;
   logic              DM_REQ, DM_WE, DM_GNT, DM_VALID;
   logic [WIDTH-1:0]  DM_ADDR, DM_WDATA, DM_RDATA;
   logic              SRAM_CEN, SRAM_WEN;
   logic [ADDR_W-1:0] SRAM_A;
   logic [WIDTH-1:0]  SRAM_D, SRAM_Q;

   mem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_DM_RUN(MAXR)) dut (
      .clk(clk), .rst(rst),
      .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT),
      .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA),
      .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR),
      .DM_WDATA(DM_WDATA), .DM_GNT(DM_GNT),
      .DM_VALID(DM_VALID), .DM_RDATA(DM_RDATA),
      .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A),
      .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i < 3) return 32'hA0 + 32'(i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   // Behavioural SRAM macro
   logic [31:0] sram [WORDS];
   bit loaded;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < WORDS; i++) sram[i] <= init_word(i);
         loaded <= 1'b1;
      end else if (!SRAM_CEN) begin
         if (!SRAM_WEN) sram[SRAM_A] <= SRAM_D;
         else           SRAM_Q <= sram[SRAM_A];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Reference model
   typedef struct { logic [31:0] data; int due; } exp_t;
   exp_t qi[$];
   exp_t qd[$];
   logic [31:0] refmem [WORDS];
   int   run;
   bit   owed;
   int   last_a;
   bit   sb_on;

   task automatic model_reset();
      run = 0; owed = 0; last_a = 0;
   endtask

   task automatic cycle(input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw,
                        input logic [31:0] da, input logic [31:0] dd,
                        output bit gi, output bit gd);
      int ea;
      @(negedge clk);
      IF_REQ = ir; IF_ADDR = ia;
      DM_REQ = dr; DM_WE = dw; DM_ADDR = da; DM_WDATA = dd;
      #1;
      gi = ir && (!dr || owed);
      gd = dr && !gi;
      if (gi)      ea = int'((ia >> 2) % WORDS);
      else if (gd) ea = int'((da >> 2) % WORDS);
      else         ea = last_a;
      chk("if_gnt", 32'(IF_GNT), 32'(gi));
      chk("dm_gnt", 32'(DM_GNT), 32'(gd));
      chk("sram_cen", 32'(SRAM_CEN), 32'(!(gi || gd)));
      chk("sram_wen", 32'(SRAM_WEN), 32'(!(gd && dw)));
      chk("sram_a", 32'(SRAM_A), 32'(ea));
      if (gd && dw) chk("sram_d", SRAM_D, dd);
      if (gi) qi.push_back('{refmem[ea], cyc + 1});
      if (gd) begin
         if (dw) begin
            qd.push_back('{32'h0, cyc + 1});
            refmem[ea] = dd;
         end else begin
            qd.push_back('{refmem[ea], cyc + 1});
         end
      end
      last_a = ea;
      // fetch is owed a turn after MAXR straight losses while waiting
      if (gi) begin
         run = 0; owed = 0;
      end else if (!ir) begin
         run = 0;
      end else if (gd) begin
         if (run < MAXR) run++;
         if (run == MAXR) owed = 1;
      end
   endtask

   // Monitor: pops expectations when the DUT presents a response
   always @(negedge clk) begin
      exp_t e;
      if (sb_on) begin
         if (qi.size() != 0 && qi[0].due == cyc) begin
            e = qi.pop_front();
            chk("if_valid", 32'(IF_VALID), 32'h1);
            chk("if_rdata", IF_RDATA, e.data);
         end else begin
            chk("if_valid_idle", 32'(IF_VALID), 32'h0);
            chk("if_rdata_idle", IF_RDATA, 32'h0);
         end
         if (qd.size() != 0 && qd[0].due == cyc) begin
            e = qd.pop_front();
            chk("dm_valid", 32'(DM_VALID), 32'h1);
            chk("dm_rdata", DM_RDATA, e.data);
         end else begin
            chk("dm_valid_idle", 32'(DM_VALID), 32'h0);
            chk("dm_rdata_idle", DM_RDATA, 32'h0);
         end
      end
   end

   initial begin
      bit gi, gd;
      bit ir, dr, dw, lgi, lgd;
      logic [31:0] ia, da, dd;
      logic [11:0] pat, pat_exp;

      for (int i = 0; i < WORDS; i++) refmem[i] = init_word(i);
      model_reset();
      sb_on = 0;
      rst = 1'b0;
      IF_REQ = 1'b1; IF_ADDR = '0;
      DM_REQ = 1'b1; DM_WE = 1'b1; DM_ADDR = '0; DM_WDATA = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_if_valid", 32'(IF_VALID), 32'h0);
      chk("rst_dm_valid", 32'(DM_VALID), 32'h0);
      chk("rst_cen", 32'(SRAM_CEN), 32'h1);
      chk("rst_wen", 32'(SRAM_WEN), 32'h1);
      chk("rst_if_rdata", IF_RDATA, 32'h0);
      chk("rst_dm_rdata", DM_RDATA, 32'h0);
      IF_REQ = 1'b0; DM_REQ = 1'b0; DM_WE = 1'b0;
      rst = 1'b1;

      // Reset lands mid-access: the granted read must vanish
      @(negedge clk);
      DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = 32'h10;
      #1 chk("mid_dm_gnt", 32'(DM_GNT), 32'h1);
      #2 rst = 1'b0;
      #1 chk("mid_cen", 32'(SRAM_CEN), 32'h1);
      @(posedge clk);
      #1;
      chk("mid_dm_valid", 32'(DM_VALID), 32'h0);
      chk("mid_dm_rdata", DM_RDATA, 32'h0);
      @(negedge clk);
      DM_REQ = 1'b0;
      rst = 1'b1;
      model_reset();
      sb_on = 1;

      cycle(1, 32'h0, 0, 0, 0, 0, gi, gd);
      cycle(1, 32'h4, 0, 0, 0, 0, gi, gd);
      cycle(1, 32'h8, 0, 0, 0, 0, gi, gd);
      cycle(0, 0, 1, 1, 32'h44, 32'hDEADBEEF, gi, gd);
      cycle(0, 0, 1, 0, 32'h44, 0, gi, gd);
      cycle(0, 0, 1, 0, 32'h2003, 0, gi, gd);
      cycle(0, 0, 0, 0, 0, 0, gi, gd);
      cycle(1, 32'h100, 1, 0, 32'h20, 0, gi, gd);
      cycle(0, 32'h100, 0, 0, 32'h20, 0, gi, gd);

      pat = '0;
      for (int i = 0; i < 12; i++) begin
         cycle(1, 32'h200, 1, 0, 32'h30, 0, gi, gd);
         pat[i] = gi;
      end
      pat_exp = 12'b0010_0001_0000;
      chk("contention_pattern", 32'(pat), 32'(pat_exp));
      cycle(0, 0, 0, 0, 0, 0, gi, gd);

      ir = 0; dr = 0; dw = 0; lgi = 0; lgd = 0;
      ia = '0; da = '0; dd = '0;
      for (int n = 0; n < 600; n++) begin
         if (ir && !lgi) begin
            if ($urandom_range(0, 7) == 0) ir = 0;
         end else begin
            ir = 1'($urandom_range(0, 1));
            ia = (32'($urandom_range(0, 31)) << 2)
                 | ($urandom & 32'hFFFF_E003);
         end
         if (dr && !lgd) begin
            if ($urandom_range(0, 7) == 0) dr = 0;
         end else begin
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            da = (32'($urandom_range(0, 31)) << 2)
                 | ($urandom & 32'hFFFF_E003);
            dd = $urandom;
         end
         cycle(ir, ia, dr, dw, da, dd, lgi, lgd);
      end

      cycle(0, 0, 0, 0, 0, 0, gi, gd);
      cycle(0, 0, 0, 0, 0, 0, gi, gd);
      @(negedge clk);
      #1 sb_on = 0;
      chk("if_queue_drained", 32'(qi.size()), 32'h0);
      chk("dm_queue_drained", 32'(qd.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
